// File: rtl/da_pkg.sv
// Shared types and elaboration helpers for the distributed-arithmetic MAC.
package da_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BUILD,
    S_READY,
    S_COMPUTE,
    S_DONE
  } state_e;

  // Accumulator width large enough for K products of A-bit by B-bit operands.
  function automatic int acc_width(input int k, input int a, input int b);
    return b + a + $clog2(k);
  endfunction

  // Index of the lowest set bit; selects which weight a build step adds.
  function automatic int ctz(input int v);
    int r;
    r = 0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/da_lut_group.sv
// One partial-sum table: entry[c] = sum of the group weights selected by the
// set bits of c. Entry 0 is never stored; the read port returns zero for it.
module da_lut_group
  import da_pkg::*;
#(
  parameter int SPLIT        = 4,
  parameter int DATA_WIDTH_B = 16
) (
  input  logic                              clk,
  input  logic [SPLIT*DATA_WIDTH_B-1:0]     i_b,
  input  logic                              i_we,
  input  logic [SPLIT-1:0]                  i_wr_idx,
  input  logic [SPLIT-1:0]                  i_rd_addr,
  output logic signed [DATA_WIDTH_B+SPLIT-1:0] o_rd_data
);

  localparam int N  = 1 << SPLIT;
  localparam int EW = DATA_WIDTH_B + SPLIT;

  logic signed [EW-1:0]           r_lut [N];
  logic [SPLIT-1:0]               w_src_idx;
  logic signed [DATA_WIDTH_B-1:0] w_b_lane;
  logic signed [EW-1:0]           w_src;
  logic signed [EW-1:0]           w_sum;

  // Each new entry reuses the entry with its lowest set bit cleared.
  always_comb begin
    w_src_idx = i_wr_idx & (i_wr_idx - SPLIT'(1));
    w_b_lane  = '0;
    for (int i = 0; i < SPLIT; i++) begin
      if (i == ctz(int'(i_wr_idx))) w_b_lane = i_b[i*DATA_WIDTH_B +: DATA_WIDTH_B];
    end
    w_src = (w_src_idx == '0) ? '0 : r_lut[w_src_idx];
    w_sum = w_src + {{SPLIT{w_b_lane[DATA_WIDTH_B-1]}}, w_b_lane};
  end

  // Table storage; contents are meaningless until a full build completes.
  always_ff @(posedge clk) begin
    if (i_we) r_lut[i_wr_idx] <= w_sum;
  end

  // Read port with the permanent zero entry.
  always_comb begin
    o_rd_data = (i_rd_addr == '0) ? '0 : r_lut[i_rd_addr];
  end

endmodule

// File: rtl/da_split_mac.sv
// Distributed-arithmetic dot product y = sum_k B[k]*A[k], bit-serial over A.
// state     | meaning
// S_IDLE    | no valid weights, waiting for a weight vector
// S_BUILD   | filling group tables, one entry per cycle
// S_READY   | tables valid, accepting weights or activations
// S_COMPUTE | walking activation bits LSB first, plus one pipeline flush cycle
// S_DONE    | result presented until downstream takes it
module da_split_mac
  import da_pkg::*;
#(
  parameter int K            = 32,
  parameter int SPLIT        = 4,
  parameter int DATA_WIDTH_A = 8,
  parameter int DATA_WIDTH_B = 16,
  parameter bit SIGNED_A     = 1'b1,
  localparam int ACC_W       = acc_width(K, DATA_WIDTH_A, DATA_WIDTH_B)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [K*DATA_WIDTH_B-1:0]     B_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [K*DATA_WIDTH_A-1:0]     A_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_W-1:0]       LUT_out,
  output logic                          lut_built
);

  localparam int GROUPS = K / SPLIT;
  localparam int N      = 1 << SPLIT;
  localparam int EW     = DATA_WIDTH_B + SPLIT;
  localparam int CW     = $clog2(N + DATA_WIDTH_A + 1);

  if (K % SPLIT != 0) begin : g_bad_split
    $error("da_split_mac: K must be a multiple of SPLIT");
  end

  state_e                      r_state;
  logic [CW-1:0]               r_cnt;
  logic [K*DATA_WIDTH_B-1:0]   r_b;
  logic [K*DATA_WIDTH_A-1:0]   r_a;
  logic signed [ACC_W-1:0]     r_acc;
  logic signed [ACC_W-1:0]     r_out;
  logic                        r_out_valid;
  logic                        r_lut_built;
  logic signed [ACC_W-1:0]     r_s;
  logic [CW-1:0]               r_s_sh;
  logic                        r_s_vld;
  logic                        r_s_last;

  logic                        w_w_hs;
  logic                        w_in_hs;
  logic                        w_we;
  logic [SPLIT-1:0]            w_build_idx;
  logic [CW-1:0]               w_j;
  logic [SPLIT-1:0]            w_addr [GROUPS];
  logic signed [EW-1:0]        w_rd [GROUPS];
  logic signed [ACC_W-1:0]     w_group_sum;
  logic signed [ACC_W-1:0]     w_term;
  logic signed [ACC_W-1:0]     w_acc_next;

  assign w_ready   = (r_state == S_IDLE) || (r_state == S_READY);
  assign in_ready  = (r_state == S_READY) && !w_valid;
  assign out_valid = r_out_valid;
  assign LUT_out   = r_out;
  assign lut_built = r_lut_built;

  assign w_w_hs      = w_valid && w_ready;
  assign w_in_hs     = in_valid && in_ready;
  assign w_we        = (r_state == S_BUILD);
  // Down-counters mapped back to ascending build index and bit position.
  assign w_build_idx = SPLIT'(CW'(N) - r_cnt);
  assign w_j         = CW'(DATA_WIDTH_A) - r_cnt;

  for (genvar g = 0; g < GROUPS; g++) begin : g_group
    da_lut_group #(
      .SPLIT        (SPLIT),
      .DATA_WIDTH_B (DATA_WIDTH_B)
    ) u_lut (
      .clk       (clk),
      .i_b       (r_b[g*SPLIT*DATA_WIDTH_B +: SPLIT*DATA_WIDTH_B]),
      .i_we      (w_we),
      .i_wr_idx  (w_build_idx),
      .i_rd_addr (w_addr[g]),
      .o_rd_data (w_rd[g])
    );
  end

  // Gather bit j of each group's activations and sum the selected entries.
  always_comb begin
    w_group_sum = '0;
    for (int g = 0; g < GROUPS; g++) begin
      for (int i = 0; i < SPLIT; i++) begin
        w_addr[g][i] = r_a[(g*SPLIT + i)*DATA_WIDTH_A + int'(w_j)];
      end
      w_group_sum = w_group_sum + ACC_W'(w_rd[g]);
    end
  end

  // Weighted slice; the activation sign bit slice is subtracted in signed mode.
  always_comb begin
    w_term     = r_s <<< r_s_sh;
    w_acc_next = (SIGNED_A && r_s_last) ? (r_acc - w_term) : (r_acc + w_term);
  end

  // Register the group sum so the table read and the accumulate sit in separate cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s      <= '0;
      r_s_sh   <= '0;
      r_s_vld  <= 1'b0;
      r_s_last <= 1'b0;
    end else begin
      r_s      <= w_group_sum;
      r_s_sh   <= w_j;
      r_s_vld  <= (r_state == S_COMPUTE) && (r_cnt != '0);
      r_s_last <= (r_cnt == CW'(1));
    end
  end

  // Control FSM with its counters, operand latches and result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_b         <= '0;
      r_a         <= '0;
      r_acc       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_lut_built <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_READY: begin
          if (w_w_hs) begin
            r_b         <= B_in;
            r_cnt       <= CW'(N - 1);
            r_lut_built <= 1'b0;
            r_state     <= S_BUILD;
          end else if (w_in_hs) begin
            r_a     <= A_in;
            r_cnt   <= CW'(DATA_WIDTH_A);
            r_acc   <= '0;
            r_state <= S_COMPUTE;
          end
        end
        S_BUILD: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_lut_built <= 1'b1;
            r_state     <= S_READY;
          end
        end
        S_COMPUTE: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
          if (r_s_vld) r_acc <= w_acc_next;
          if (r_s_vld && r_s_last) begin
            r_out       <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_READY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_split_mac.sv
// Directed bench for da_split_mac (K=8, SPLIT=4, A=8, B=16), signed and unsigned copies.
module tb_da_split_mac;
  localparam int K     = 8;
  localparam int ACC_W = 27;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic w_valid = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [K*16-1:0] B_in = '0;
  logic [K*8-1:0]  A_in = '0;

  logic w_ready_s, in_ready_s, out_valid_s, lut_built_s;
  logic w_ready_u, in_ready_u, out_valid_u, lut_built_u;
  logic signed [ACC_W-1:0] lut_out_s, lut_out_u;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  da_split_mac #(.K(8), .SPLIT(4), .DATA_WIDTH_A(8), .DATA_WIDTH_B(16), .SIGNED_A(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready_s), .B_in(B_in),
    .in_valid(in_valid), .in_ready(in_ready_s), .A_in(A_in), .out_valid(out_valid_s),
    .out_ready(out_ready), .LUT_out(lut_out_s), .lut_built(lut_built_s));

  da_split_mac #(.K(8), .SPLIT(4), .DATA_WIDTH_A(8), .DATA_WIDTH_B(16), .SIGNED_A(1'b0)) u_dut_u (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_ready(w_ready_u), .B_in(B_in),
    .in_valid(in_valid), .in_ready(in_ready_u), .A_in(A_in), .out_valid(out_valid_u),
    .out_ready(out_ready), .LUT_out(lut_out_u), .lut_built(lut_built_u));

  task automatic set_b(input logic [15:0] b [K]);
    for (int k = 0; k < K; k++) B_in[k*16 +: 16] = b[k];
  endtask

  task automatic set_a(input logic [7:0] a [K]);
    for (int k = 0; k < K; k++) A_in[k*8 +: 8] = a[k];
  endtask

  // Weight handshake, then count build cycles until lut_built.
  task automatic load_w();
    int n;
    @(negedge clk);
    w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    n = 0;
    while (!lut_built_s && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL build_len: got %0d cycles, expected 15", n);
    end
  endtask

  // Activation handshake, then count cycles until out_valid (bounded).
  task automatic send_a(output int lat);
    @(negedge clk);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid_s && lat < 40);
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid_s !== 1'b0 || in_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL drain: out_valid=%b in_ready=%b, expected 0/1", out_valid_s, in_ready_s);
    end
  endtask

  task automatic run_case(input string name, input logic signed [ACC_W-1:0] exp_s,
                          input logic signed [ACC_W-1:0] exp_u);
    int lat;
    send_a(lat);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL %s_latency: got %0d, expected 9", name, lat);
    end
    checks++;
    if (lut_out_s !== exp_s) begin
      errors++;
      $display("FAIL %s_signed: got %0d, expected %0d", name, lut_out_s, exp_s);
    end
    checks++;
    if (lut_out_u !== exp_u) begin
      errors++;
      $display("FAIL %s_unsigned: got %0d, expected %0d", name, lut_out_u, exp_u);
    end
    take_result();
  endtask

  task automatic test_reset();
    logic [15:0] b [K];
    rst = 1'b0;
    #12;
    checks++;
    if (w_ready_s !== 1'b1 || in_ready_s !== 1'b0 || out_valid_s !== 1'b0 ||
        lut_out_s !== '0 || lut_built_s !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: w_ready=%b in_ready=%b out_valid=%b LUT_out=%0d built=%b",
               w_ready_s, in_ready_s, out_valid_s, lut_out_s, lut_built_s);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < K; k++) b[k] = 16'd1;
    set_b(b);
    @(negedge clk);
    w_valid = 1'b1;
    @(posedge clk); #1;
    w_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    checks++;
    if (w_ready_s !== 1'b0) begin
      errors++;
      $display("FAIL build_w_ready: got %b, expected 0", w_ready_s);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (w_ready_s !== 1'b1 || in_ready_s !== 1'b0 || out_valid_s !== 1'b0 || lut_built_s !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: w_ready=%b in_ready=%b out_valid=%b built=%b, expected 1/0/0/0",
               w_ready_s, in_ready_s, out_valid_s, lut_built_s);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (lut_built_s !== 1'b0 || w_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL reset_discard: built=%b w_ready=%b, expected 0/1", lut_built_s, w_ready_s);
    end
  endtask

  task automatic test_basic();
    logic [7:0] a [K];
    logic [15:0] b [K];
    for (int k = 0; k < K; k++) begin b[k] = 16'd1; a[k] = 8'd3; end
    set_b(b);
    load_w();
    set_a(a);
    run_case("basic", 27'sd24, 27'sd24);
  endtask

  task automatic test_all_ones();
    logic [7:0] a [K];
    for (int k = 0; k < K; k++) a[k] = 8'hFF;
    set_a(a);
    run_case("ones", -27'sd8, 27'sd2040);
  endtask

  task automatic test_extremes();
    logic [7:0] a [K];
    logic [15:0] b [K];
    for (int k = 0; k < K; k++) begin b[k] = 16'h8000; a[k] = 8'h80; end
    set_b(b);
    load_w();
    set_a(a);
    run_case("extreme", 27'sd33554432, -27'sd33554432);
  endtask

  task automatic test_mixed();
    logic [7:0] a [K];
    logic [15:0] b [K];
    for (int k = 0; k < K; k++) begin b[k] = 16'(k + 1); a[k] = 8'(k + 1); end
    b[7] = 16'hFFF8;
    a[0] = 8'hFE;
    set_b(b);
    load_w();
    set_a(a);
    run_case("mixed", 27'sd73, 27'sd329);
  endtask

  task automatic test_backpressure();
    logic [7:0] a [K];
    int lat;
    logic signed [ACC_W-1:0] held;
    for (int k = 0; k < K; k++) a[k] = 8'd1;
    set_a(a);
    send_a(lat);
    held = 27'sd20;
    for (int k = 0; k < K; k++) a[k] = 8'd2;
    @(negedge clk);
    set_a(a);
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (lut_out_s !== held || out_valid_s !== 1'b1 || in_ready_s !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d: LUT_out=%0d out_valid=%b in_ready=%b, expected %0d/1/0",
                 c, lut_out_s, out_valid_s, in_ready_s, held);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready_s !== 1'b1 || out_valid_s !== 1'b0) begin
      errors++;
      $display("FAIL post_drain: in_ready=%b out_valid=%b, expected 1/0", in_ready_s, out_valid_s);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid_s && lat < 40);
    checks++;
    if (lat != 9 || lut_out_s !== 27'sd40) begin
      errors++;
      $display("FAIL next_vector: LUT_out=%0d lat=%0d, expected 40/9", lut_out_s, lat);
    end
    take_result();
  endtask

  task automatic test_w_and_in();
    logic [7:0] a [K];
    logic [15:0] b [K];
    int n;
    int lat;
    for (int k = 0; k < K; k++) begin b[k] = 16'd2; a[k] = 8'd3; end
    @(negedge clk);
    set_b(b);
    set_a(a);
    w_valid = 1'b1;
    in_valid = 1'b1;
    #1;
    checks++;
    if (in_ready_s !== 1'b0 || w_ready_s !== 1'b1) begin
      errors++;
      $display("FAIL priority: in_ready=%b w_ready=%b, expected 0/1", in_ready_s, w_ready_s);
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
    checks++;
    if (lut_built_s !== 1'b0 || in_ready_s !== 1'b0) begin
      errors++;
      $display("FAIL rebuild_start: built=%b in_ready=%b, expected 0/0", lut_built_s, in_ready_s);
    end
    n = 0;
    while (!lut_built_s && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL rebuild_len: got %0d, expected 15", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid_s && lat < 40);
    checks++;
    if (lat != 9 || lut_out_s !== 27'sd48 || lut_out_u !== 27'sd48) begin
      errors++;
      $display("FAIL new_weights: LUT_out=%0d/%0d lat=%0d, expected 48/48/9", lut_out_s, lut_out_u, lat);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_ones();
    test_extremes();
    test_mixed();
    test_backpressure();
    test_w_and_in();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
